// File: rtl/wb_bridge_pkg.sv
// Shared types and widths for the core-to-Wishbone bridge.
package wb_bridge_pkg;

  localparam int unsigned MaxOutstLimit = 7;
  localparam int unsigned CntW = $clog2(MaxOutstLimit + 1);
  localparam int unsigned TmrW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain,
    StFlush
  } bridge_state_e;

endpackage

// File: rtl/if_wb.sv
// Wishbone pipelined bus bundle with master and slave views.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack, err, stall
  );

endinterface

// File: rtl/core2wb_bridge.sv
// Core request/grant port to Wishbone pipelined master, with outstanding-request
// tracking, error drain and a response watchdog that aborts the bus cycle.
module core2wb_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  if_wb.master        wb
);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTST);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  bridge_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;

  logic issue;
  logic flush;
  logic busy;
  logic resp;
  logic timeout;

  assign flush = (state_q == StFlush);
  assign busy  = (cnt_q != '0);
  assign issue = req_i & ((state_q == StIdle) | (state_q == StActive)) & (cnt_q < MaxCnt);
  assign resp  = (wb.ack | wb.err) & busy & ~flush;

  assign wb.stb   = issue;
  assign wb.cyc   = issue | (busy & ~flush);
  assign wb.we    = issue & we_i;
  assign wb.sel   = issue ? be_i : 4'h0;
  assign wb.adr   = issue ? addr_i : 32'h0;
  assign wb.dat_o = issue ? wdata_i : 32'h0;
  assign gnt_o    = issue & ~wb.stall;

  // While flushing, every cycle retires one aborted request as an error.
  assign rvalid_o = flush | resp;
  assign err_o    = flush | wb.err;
  assign rdata_o  = flush ? 32'h0 : wb.dat_i;

  assign timeout = (tmr_q == TmrLast) & ~resp & busy;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (gnt_o & ~resp) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (~gnt_o & resp) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    tmr_d = tmr_q + TmrW'(1);
    if (~busy | resp) begin
      tmr_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_o) state_d = StActive;
      end
      StActive: begin
        if (timeout) begin
          state_d = StFlush;
        end else if (cnt_d == '0) begin
          state_d = StIdle;
        end else if (resp & wb.err) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (timeout) begin
          state_d = StFlush;
        end else if (cnt_d == '0) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (cnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_core2wb_bridge.sv
// Randomised and directed bench for core2wb_bridge against a queue-based model
// of outstanding transactions and an in-order pipelined slave.
module tb_core2wb_bridge;

  localparam int unsigned MaxOut = 2;
  localparam int unsigned Tmo    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;

  if_wb wb_bus ();

  core2wb_bridge #(
    .MAX_OUTST(MaxOut),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .wb      (wb_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } sl_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: in-order responses, one per cycle, each no earlier than its due cycle.
  sl_t sl_q[$];
  int  last_due = 0;
  int  cyc_no = 0;
  int  sl_delay = 1;
  bit  sl_silent = 0;
  bit  sl_err_next = 0;

  // Reference model: queue of expected read data for requests still owed a response.
  logic [31:0] m_q[$];
  int          m_tmr = 0;
  bit          m_drain = 0;
  bit          m_flush = 0;

  bit           e_gnt, e_resp, e_err_in, s_pop;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [105:0] exp_v;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [105:0] obs();
    return {wb_bus.cyc, wb_bus.stb, gnt_o, rvalid_o, err_o, wb_bus.we, wb_bus.sel,
            wb_bus.adr, wb_bus.dat_o, rdata_o};
  endfunction

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input logic st,
                       input logic xa);
    bit          issue, ack, err, busy;
    logic [31:0] dat;
    req_i = r; we_i = w; be_i = b; addr_i = a; wdata_i = d; wb_bus.stall = st;
    d_we = w; d_addr = a;
    ack = 0; err = 0; dat = 32'h0; s_pop = 0;
    if (!sl_silent && sl_q.size() > 0 && sl_q[0].due <= cyc_no) begin
      s_pop = 1;
      dat   = sl_q[0].data;
      if (sl_q[0].err) err = 1;
      else ack = 1;
    end
    if (xa) ack = 1;
    wb_bus.ack = ack; wb_bus.err = err; wb_bus.dat_i = dat;
    busy     = (m_q.size() != 0);
    issue    = r && !m_drain && !m_flush && (m_q.size() < MaxOut);
    e_gnt    = issue && !st;
    e_resp   = (ack || err) && busy && !m_flush;
    e_err_in = err;
    exp_v = {issue || (busy && !m_flush), issue, e_gnt, m_flush || e_resp, m_flush || err,
             issue && w, issue ? b : 4'h0, issue ? a : 32'h0, issue ? d : 32'h0,
             m_flush ? 32'h0 : (e_resp ? m_q[0] : dat)};
    @(negedge clk);
  endtask

  task automatic advance();
    int  old_n, due;
    bit  tout;
    sl_t t;
    old_n = m_q.size();
    tout  = (m_tmr == Tmo - 1) && !e_resp && (old_n != 0);
    m_tmr = (old_n == 0 || e_resp) ? 0 : m_tmr + 1;
    if (s_pop) void'(sl_q.pop_front());
    if ((e_resp || m_flush) && old_n != 0) void'(m_q.pop_front());
    if (e_gnt) begin
      m_q.push_back(d_we ? 32'h0 : rd_data(d_addr));
      due = cyc_no + sl_delay;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      t.due = due; t.err = sl_err_next; t.data = d_we ? 32'h0 : rd_data(d_addr);
      sl_q.push_back(t);
      sl_err_next = 0;
    end
    if (!m_flush && tout) begin
      m_flush = 1; m_drain = 0;
      sl_q.delete();
    end else if (m_q.size() == 0) begin
      m_flush = 0; m_drain = 0;
    end else if (e_resp && e_err_in) begin
      m_drain = 1;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
    wb_bus.ack = 0; wb_bus.err = 0; wb_bus.stall = 0; wb_bus.dat_i = 0;
    @(posedge clk);
    #1;
    cyc_no++;
    m_q.delete(); sl_q.delete();
    m_tmr = 0; m_drain = 0; m_flush = 0; last_due = 0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (obs() !== 106'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs(), 106'h0);
    end
    @(posedge clk);
    #1;
    cyc_no++;
    rst = 1'b0;
    drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("FAIL reset_idle c%0d got=%h want=%h", cyc_no, obs(), exp_v);
    end
    advance();
  endtask

  task automatic test_single_read();
    sl_delay = 1;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 0, 4'hF, 32'h100, 32'h0, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL single_read c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    sl_delay = 3;
    for (int i = 0; i < 16; i++) begin
      drive(k < 3, 1, 4'hF, 32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      if (e_gnt) k++;
      advance();
    end
  endtask

  task automatic test_stall();
    sl_delay = 1;
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 1, 4'h3, 32'h340, 32'h1234_5678, i < 4, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL stall c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      advance();
    end
  endtask

  task automatic test_err_drain();
    int k = 0;
    sl_delay = 2;
    sl_err_next = 1;
    for (int i = 0; i < 14; i++) begin
      drive(i < 8, 0, 4'hF, 32'h400 + 32'(k * 4), 32'h0, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL err_drain c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      if (e_gnt) k++;
      advance();
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    sl_silent = 1;
    for (int i = 0; i < 20; i++) begin
      drive(i < 2, 0, 4'hF, 32'h500 + 32'(i * 4), 32'h0, 0, m_flush);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL timeout c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      if (rvalid_o === 1'b1) pulses++;
      advance();
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL timeout_pulses got=%0d want=2", pulses);
    end
    sl_q.delete();
    sl_silent = 0;
    drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("FAIL late_ack c%0d got=%h want=%h", cyc_no, obs(), exp_v);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    sl_delay = 4;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 4'hF, 32'h600 + 32'(i * 4), 32'h0, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_issue c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      advance();
    end
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_after c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic        r, w, st;
    logic [3:0]  b;
    logic [31:0] a, d;
    for (int i = 0; i < 440; i++) begin
      r  = (i < 400) && ($urandom_range(9) < 7);
      w  = $urandom_range(1);
      st = ($urandom_range(3) == 0);
      b  = 4'($urandom_range(15));
      a  = {$urandom_range(32'hFFFF), 2'b00};
      d  = $urandom;
      sl_delay = $urandom_range(1, 4);
      sl_err_next = ($urandom_range(7) == 0);
      drive(r, w, b, a, d, st, 0);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL random c%0d got=%h want=%h", cyc_no, obs(), exp_v);
      end
      advance();
    end
    sl_err_next = 0;
  endtask

  initial begin
    rst = 1'b1;
    req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
    wb_bus.ack = 0; wb_bus.err = 0; wb_bus.stall = 0; wb_bus.dat_i = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_err_drain();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
